// File: rtl/intctl.sv
// Single-level interrupt controller: latches irq edges, masks them, requests the control
// unit for the highest-priority source, then drives vector-load and return-address restore.
module intctl #(
  parameter int              NSRC     = 4,
  parameter int              PCW      = 10,
  parameter logic [PCW-1:0]  VEC_BASE = 10'h3C0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  output logic [NSRC-1:0] mask_q,
  input  logic            ack,
  input  logic [PCW-1:0]  pc_cur,
  input  logic            reti,
  output logic            int_req,
  output logic            vec_load,
  output logic [PCW-1:0]  pc_vec,
  output logic            ret_load,
  output logic [PCW-1:0]  pc_ret,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service
);

  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Index 0 is the highest priority, so the lowest set bit wins.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NSRC-1:0] v);
    logic [SEL_W-1:0] r;
    r = {SEL_W{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  state_t          state_r;
  logic [NSRC-1:0] irq_d_r;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] in_service_r;
  logic [PCW-1:0]  pc_ret_r;
  logic [PCW-1:0]  pc_vec_r;
  logic            int_req_r;
  logic            vec_load_r;
  logic            ret_load_r;

  logic [NSRC-1:0] eligible_s;
  logic [SEL_W-1:0] sel_s;
  logic [NSRC-1:0] sel_onehot_s;
  logic [PCW-1:0]  req_vec_s;
  logic            take_s;
  logic [NSRC-1:0] set_s;
  logic [NSRC-1:0] clr_s;

  // Source selection, vector arithmetic and pending set/clear terms.
  always_comb begin
    eligible_s   = pending_r & mask_r;
    sel_s        = lowest_set(eligible_s);
    sel_onehot_s = {{(NSRC-1){1'b0}}, 1'b1} << sel_s;
    req_vec_s    = VEC_BASE + (PCW'(sel_s) << 2);
    take_s       = (state_r == ST_REQ) && ack && (eligible_s != {NSRC{1'b0}});
    set_s        = irq & ~irq_d_r;
    if (take_s) begin
      clr_s = sel_onehot_s;
    end else begin
      clr_s = {NSRC{1'b0}};
    end
  end

  // Edge latch, mask register and the IDLE/REQ/SERVICE sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      irq_d_r      <= {NSRC{1'b0}};
      pending_r    <= {NSRC{1'b0}};
      mask_r       <= {NSRC{1'b0}};
      in_service_r <= {NSRC{1'b0}};
      pc_ret_r     <= {PCW{1'b0}};
      pc_vec_r     <= VEC_BASE;
      int_req_r    <= 1'b0;
      vec_load_r   <= 1'b0;
      ret_load_r   <= 1'b0;
    end else begin
      irq_d_r    <= irq;
      // A fresh edge in the clearing cycle must survive, so set is applied last.
      pending_r  <= (pending_r & ~clr_s) | set_s;
      vec_load_r <= 1'b0;
      ret_load_r <= 1'b0;
      if (mask_we) begin
        mask_r <= mask_d;
      end else begin
        mask_r <= mask_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (eligible_s != {NSRC{1'b0}}) begin
            state_r   <= ST_REQ;
            int_req_r <= 1'b1;
          end else begin
            int_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (eligible_s == {NSRC{1'b0}}) begin
            state_r   <= ST_IDLE;
            int_req_r <= 1'b0;
          end else if (take_s) begin
            state_r      <= ST_SERVICE;
            int_req_r    <= 1'b0;
            pc_ret_r     <= pc_cur;
            pc_vec_r     <= req_vec_s;
            in_service_r <= sel_onehot_s;
            vec_load_r   <= 1'b1;
          end else begin
            int_req_r <= 1'b1;
          end
        end
        ST_SERVICE: begin
          int_req_r <= 1'b0;
          if (reti) begin
            state_r      <= ST_IDLE;
            in_service_r <= {NSRC{1'b0}};
            ret_load_r   <= 1'b1;
          end else begin
            state_r <= ST_SERVICE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          int_req_r    <= 1'b0;
          in_service_r <= {NSRC{1'b0}};
        end
      endcase
    end
  end

  assign mask_q     = mask_r;
  assign pending    = pending_r;
  assign in_service = in_service_r;
  assign pc_ret     = pc_ret_r;
  assign int_req    = int_req_r;
  assign vec_load   = vec_load_r;
  assign ret_load   = ret_load_r;
  // While requesting, the vector tracks the current winner; otherwise it holds the taken one.
  assign pc_vec     = (state_r == ST_REQ) ? req_vec_s : pc_vec_r;

endmodule

// File: tb/tb_intctl.sv
// Scoreboard bench for intctl: a spec-level model predicts per-cycle state and
// queues expected vector/return pulses that a monitor process checks.
module tb_intctl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_d;
  logic [3:0] mask_q;
  logic       ack;
  logic [9:0] pc_cur;
  logic       reti;
  logic       int_req;
  logic       vec_load;
  logic [9:0] pc_vec;
  logic       ret_load;
  logic [9:0] pc_ret;
  logic [3:0] pending;
  logic [3:0] in_service;

  intctl dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_d(mask_d),
    .mask_q(mask_q), .ack(ack), .pc_cur(pc_cur), .reti(reti), .int_req(int_req),
    .vec_load(vec_load), .pc_vec(pc_vec), .ret_load(ret_load), .pc_ret(pc_ret),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_ret;
    logic [9:0] pcv;
    logic [9:0] pcr;
    logic [3:0] isv;
  } ev_t;
  ev_t sb[$];

  // Model state, kept in the terms of the description: waiting / requesting / servicing.
  int         m_mode;   // 0 waiting, 1 requesting, 2 servicing
  logic [3:0] m_pend, m_mask, m_irqd, m_insvc;
  logic [9:0] m_ret, m_vec;
  bit         m_vl, m_rl;

  // Stimulus for the next cycle; strobes are cleared after each tick.
  logic [3:0] d_irq, d_md;
  logic       d_mwe, d_ack, d_reti;
  logic [9:0] d_pc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_src(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 4;
  endfunction

  function automatic logic [9:0] vec_of(input int s);
    int a;
    a = (32'h3C0 + 4 * s) % 1024;
    return a[9:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 4'd0; m_mask = 4'd0; m_irqd = 4'd0; m_insvc = 4'd0;
    m_ret = 10'd0; m_vec = 10'h3C0; m_vl = 1'b0; m_rl = 1'b0;
    sb.delete();
  endtask

  // Advance the model across one rising edge with the inputs being applied.
  task automatic model_step();
    int         s;
    int         nmode;
    logic [3:0] clr;
    ev_t        e;
    s = first_src(m_pend & m_mask);
    clr = 4'd0; nmode = m_mode; m_vl = 1'b0; m_rl = 1'b0;
    if (m_mode == 0) begin
      if (s < 4) nmode = 1;
    end else if (m_mode == 1) begin
      if (s == 4) nmode = 0;
      else if (d_ack) begin
        clr[s] = 1'b1; m_ret = d_pc; m_insvc = 4'd0; m_insvc[s] = 1'b1;
        m_vec = vec_of(s); m_vl = 1'b1; nmode = 2;
        e.is_ret = 1'b0; e.pcv = m_vec; e.pcr = d_pc; e.isv = m_insvc;
        sb.push_back(e);
      end
    end else if (d_reti) begin
      m_rl = 1'b1; m_insvc = 4'd0; nmode = 0;
      e.is_ret = 1'b1; e.pcv = 10'd0; e.pcr = m_ret; e.isv = 4'd0;
      sb.push_back(e);
    end
    m_pend = (m_pend & ~clr) | (d_irq & ~m_irqd);
    m_irqd = d_irq;
    if (d_mwe) m_mask = d_md;
    m_mode = nmode;
  endtask

  task automatic compare_all();
    check("int_req",    32'(int_req),    32'(m_mode == 1));
    check("vec_load",   32'(vec_load),   32'(m_vl));
    check("ret_load",   32'(ret_load),   32'(m_rl));
    check("pending",    32'(pending),    32'(m_pend));
    check("mask_q",     32'(mask_q),     32'(m_mask));
    check("in_service", 32'(in_service), 32'(m_insvc));
    check("pc_ret",     32'(pc_ret),     32'(m_ret));
    if (m_mode != 1) check("pc_vec_held", 32'(pc_vec), 32'(m_vec));
    else if ((m_pend & m_mask) != 4'd0)
      check("pc_vec_req", 32'(pc_vec), 32'(vec_of(first_src(m_pend & m_mask))));
  endtask

  // Called just after a falling edge: apply inputs, cross one rising edge, compare.
  task automatic tick();
    irq = d_irq; mask_we = d_mwe; mask_d = d_md; ack = d_ack; reti = d_reti; pc_cur = d_pc;
    model_step();
    d_mwe = 1'b0; d_ack = 1'b0; d_reti = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Monitor: every vector/return pulse must match the next queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset && (vec_load || ret_load)) begin
        check("pulse_exclusive", 32'(vec_load && ret_load), 32'd0);
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: vec_load=%0b ret_load=%0b, expected none", vec_load, ret_load);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'(ret_load), 32'(e.is_ret));
          check("pulse_pc_ret", 32'(pc_ret), 32'(e.pcr));
          if (vec_load) begin
            check("pulse_pc_vec", 32'(pc_vec), 32'(e.pcv));
            check("pulse_in_service", 32'(in_service), 32'(e.isv));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] saved;
    reset = 1'b0; irq = 4'd0; mask_we = 1'b0; mask_d = 4'd0; ack = 1'b0; reti = 1'b0; pc_cur = 10'd0;
    d_irq = 4'd0; d_md = 4'd0; d_mwe = 1'b0; d_ack = 1'b0; d_reti = 1'b0; d_pc = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Reset and mask, then a single event on source 2.
    d_mwe = 1'b1; d_md = 4'b1111; tick();
    d_irq = 4'b0100; tick();
    check("s1_pending", 32'(pending), 32'h4);
    check("s1_no_req_yet", 32'(int_req), 32'd0);
    tick();
    check("s1_int_req", 32'(int_req), 32'd1);
    check("s1_pc_vec", 32'(pc_vec), 32'h3C8);
    d_ack = 1'b1; d_pc = 10'h045; tick();
    check("s1_vec_load", 32'(vec_load), 32'd1);
    check("s1_pc_ret", 32'(pc_ret), 32'h045);
    check("s1_in_service", 32'(in_service), 32'h4);
    check("s1_pending_clr", 32'(pending), 32'h0);
    d_irq = 4'd0; tick();
    d_reti = 1'b1; tick();
    tick();

    // Priority override while requesting.
    d_irq = 4'b1000; tick();
    d_irq = 4'd0; tick();
    check("s2_pc_vec3", 32'(pc_vec), 32'h3CC);
    d_irq = 4'b0010; tick();
    check("s2_pc_vec1", 32'(pc_vec), 32'h3C4);
    d_irq = 4'd0; d_ack = 1'b1; d_pc = 10'h123; tick();
    check("s2_in_service", 32'(in_service), 32'h2);
    check("s2_pending", 32'(pending), 32'h8);
    tick();
    d_reti = 1'b1; tick();
    check("s2_ret_load", 32'(ret_load), 32'd1);
    tick();
    check("s2_rereq", 32'(int_req), 32'd1);
    check("s2_rereq_vec", 32'(pc_vec), 32'h3CC);
    d_ack = 1'b1; tick();
    d_reti = 1'b1; tick();
    tick();

    // Masked event held pending.
    d_mwe = 1'b1; d_md = 4'b0000; tick();
    d_irq = 4'b0001; tick();
    d_irq = 4'd0;
    repeat (20) begin
      tick();
      check("s3_masked_no_req", 32'(int_req), 32'd0);
    end
    check("s3_pending", 32'(pending), 32'h1);
    d_mwe = 1'b1; d_md = 4'b0001; tick();
    tick();
    check("s3_unmask_req", 32'(int_req), 32'd1);
    d_ack = 1'b1; tick();
    d_reti = 1'b1; tick();
    tick();

    // No nesting while servicing source 2.
    d_mwe = 1'b1; d_md = 4'b1111; tick();
    d_irq = 4'b0100; tick();
    d_irq = 4'd0; tick();
    d_ack = 1'b1; d_pc = 10'h2AA; tick();
    d_irq = 4'b0001; tick();
    d_irq = 4'd0;
    repeat (3) begin
      tick();
      check("s4_no_nest", 32'(int_req), 32'd0);
    end
    check("s4_pending0", 32'(pending[0]), 32'd1);
    saved = pc_ret;
    d_reti = 1'b1; tick();
    check("s4_ret_load", 32'(ret_load), 32'd1);
    check("s4_pc_ret", 32'(pc_ret), 32'h2AA);
    tick();
    check("s4_req", 32'(int_req), 32'd1);
    check("s4_pc_vec", 32'(pc_vec), 32'h3C0);
    check("s4_pc_ret_stable", 32'(pc_ret), 32'(saved));
    d_ack = 1'b1; tick();
    d_reti = 1'b1; tick();
    tick();

    // Fresh edge on the source being taken survives the clear.
    d_irq = 4'b0010; tick();
    d_irq = 4'd0; tick();
    d_ack = 1'b1; d_irq = 4'b0010; tick();
    check("s5_pending_kept", 32'(pending), 32'h2);
    d_reti = 1'b1; tick();
    tick();
    d_ack = 1'b1; tick();
    repeat (3) tick();
    check("s5_no_retrigger", 32'(pending), 32'h0);
    d_reti = 1'b1; tick();
    d_irq = 4'd0; tick();

    // Asynchronous reset in the middle of service.
    d_irq = 4'b0100; tick();
    d_irq = 4'd0; tick();
    d_ack = 1'b1; d_pc = 10'h155; tick();
    tick();
    #2; reset = 1'b0; #1;
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_vec_load", 32'(vec_load), 32'd0);
    check("rst_ret_load", 32'(ret_load), 32'd0);
    check("rst_pc_vec", 32'(pc_vec), 32'h3C0);
    check("rst_pc_ret", 32'(pc_ret), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_in_service", 32'(in_service), 32'h0);
    check("rst_mask", 32'(mask_q), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    d_reti = 1'b1; tick();
    d_ack = 1'b1; tick();
    tick();

    // Randomized traffic against the model.
    d_mwe = 1'b1; d_md = 4'b1111; tick();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) d_irq[b] = ~d_irq[b];
      if ($urandom_range(0, 15) == 0) begin d_mwe = 1'b1; d_md = 4'($urandom_range(0, 15)); end
      d_ack  = ($urandom_range(0, 2) == 0);
      d_reti = ($urandom_range(0, 5) == 0);
      d_pc   = 10'($urandom_range(0, 1023));
      tick();
    end
    d_irq = 4'd0; tick();
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
